// File: rtl/mu0_control.sv
// ---------------------------------------------------------------------------
// mu0_control
// Fetch/execute control FSM for the MU0 16-bit processor. Drives the datapath
// mux selects, ALU function code, register clock enables and memory request,
// and decodes the opcode F = IR[15:12] fed back from the datapath.
//
// Parameters
//   WAIT_STATES  extra cycles added to every memory access (0..15)
//
// Ports
//   Clk     in   system clock, rising edge
//   Reset   in   synchronous, active-high reset
//   F       in   opcode IR[15:12], valid during EXECUTE
//   N, Z    in   ACC negative / zero flags
//   X_sel   out  address mux: 0 = PC, 1 = IR[11:0]
//   Y_sel   out  ALU A mux: 0 = ACC, 1 = PC
//   B_sel   out  ALU B mux: 0 = memory data, 1 = {4'h0, IR[11:0]}
//   ALU_fs  out  00 = B, 01 = A+B, 10 = A-B, 11 = A+1
//   ACC_ce, PC_ce, IR_ce  out  register load enables
//   ACC_oe  out  ACC drives memory write data
//   MEMrq   out  memory request
//   RnW     out  1 = read, 0 = write
//   Fetch   out  high in FETCH state
//   Halted  out  high in HALTED state
// ---------------------------------------------------------------------------
module mu0_control #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       B_sel,
    output logic [1:0] ALU_fs,
    output logic       ACC_ce,
    output logic       PC_ce,
    output logic       IR_ce,
    output logic       ACC_oe,
    output logic       MEMrq,
    output logic       RnW,
    output logic       Fetch,
    output logic       Halted
);

    typedef enum logic [1:0] {
        FETCH,
        EXECUTE,
        HALTED
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t     state, state_nx;
    logic [3:0] wcnt, wcnt_nx;
    logic       last;
    logic       mem_op;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= FETCH;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        X_sel    = 1'b0;
        Y_sel    = 1'b0;
        B_sel    = 1'b0;
        ALU_fs   = 2'b00;
        ACC_ce   = 1'b0;
        PC_ce    = 1'b0;
        IR_ce    = 1'b0;
        ACC_oe   = 1'b0;
        MEMrq    = 1'b0;
        RnW      = 1'b1;
        Fetch    = 1'b0;
        Halted   = 1'b0;
        state_nx = state;
        // wcnt clears unless an access is still in progress
        wcnt_nx  = '0;
        last     = (wcnt == WS);
        mem_op   = 1'b0;

        // Reset masks every output so an aborted access fires no enable
        if (!Reset) begin
            case (state)
                FETCH: begin
                    Fetch  = 1'b1;
                    MEMrq  = 1'b1;
                    Y_sel  = 1'b1;
                    ALU_fs = 2'b11;
                    if (last) begin
                        IR_ce    = 1'b1;
                        PC_ce    = 1'b1;
                        state_nx = EXECUTE;
                    end else begin
                        wcnt_nx = wcnt + 4'd1;
                    end
                end

                EXECUTE: begin
                    state_nx = FETCH;
                    case (F)
                        4'h0: begin
                            X_sel  = 1'b1;
                            MEMrq  = 1'b1;
                            ACC_ce = last;
                            mem_op = 1'b1;
                        end
                        4'h1: begin
                            X_sel  = 1'b1;
                            MEMrq  = 1'b1;
                            RnW    = 1'b0;
                            ACC_oe = 1'b1;
                            mem_op = 1'b1;
                        end
                        4'h2: begin
                            X_sel  = 1'b1;
                            MEMrq  = 1'b1;
                            ALU_fs = 2'b01;
                            ACC_ce = last;
                            mem_op = 1'b1;
                        end
                        4'h3: begin
                            X_sel  = 1'b1;
                            MEMrq  = 1'b1;
                            ALU_fs = 2'b10;
                            ACC_ce = last;
                            mem_op = 1'b1;
                        end
                        4'h4: begin
                            B_sel = 1'b1;
                            PC_ce = 1'b1;
                        end
                        4'h5: begin
                            if (!N) begin
                                B_sel = 1'b1;
                                PC_ce = 1'b1;
                            end
                        end
                        4'h6: begin
                            if (!Z) begin
                                B_sel = 1'b1;
                                PC_ce = 1'b1;
                            end
                        end
                        4'h7: state_nx = HALTED;
                        default: ;
                    endcase
                    // Only memory ops stretch over wait states; others finish at once
                    if (mem_op && !last) begin
                        state_nx = EXECUTE;
                        wcnt_nx  = wcnt + 4'd1;
                    end
                end

                HALTED: Halted = 1'b1;

                default: state_nx = FETCH;
            endcase
        end
    end

endmodule
